// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
// Reset and reconfiguration sequencer for a Gowin rPLL in dynamic-select mode.
// The block owns the PLL RESET pin and the IDSEL/FBDSEL/ODSEL/DUTYDA buses.
// New divider codes are only ever presented while RESET is held high. After
// RESET is released it waits for a debounced LOCK, retries on timeout, and
// keeps the core reset asserted until the PLL output clock is usable.
// Runs entirely on the free-running board clock.
module pll_reconfig_ctrl #(
    parameter int         RST_CYCLES   = 16,
    parameter int         LOCK_TIMEOUT = 65536,
    parameter int         LOCK_STABLE  = 1024,
    parameter int         MAX_RETRY    = 3,
    parameter logic [5:0] INIT_IDSEL   = 6'd0,
    parameter logic [5:0] INIT_FBDSEL  = 6'd0,
    parameter logic [5:0] INIT_ODSEL   = 6'd0,
    parameter logic [3:0] INIT_DUTYDA  = 4'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_req,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    input  logic [3:0] cfg_dutyda,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_error,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic [3:0] pll_dutyda,
    input  logic       pll_lock,
    output logic       clk_ready,
    output logic       sys_reset
);

    // Counter widths: each counter only has to reach its limit minus one,
    // because it is either cleared on state entry or stops at the limit.
    localparam int RST_W = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
    localparam int TMR_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int STB_W = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;
    localparam int RTY_W = (MAX_RETRY    > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    localparam logic [2:0] ST_RST    = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_STABLE = 3'd2;
    localparam logic [2:0] ST_READY  = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    logic [2:0]       state_reg;
    logic [RST_W-1:0] rst_cnt_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [STB_W-1:0] stable_cnt_reg;
    logic [RTY_W-1:0] retry_reg;
    logic             lock_meta_reg;
    logic             lock_s_reg;

    logic rst_done;
    logic stable_done;
    logic timed_out;
    logic retry_left;

    assign rst_done    = (rst_cnt_reg == RST_LAST);
    assign stable_done = lock_s_reg && (stable_cnt_reg == STB_LAST);
    assign timed_out   = (timer_reg == TMR_LAST);
    assign retry_left  = (retry_reg < RTY_MAX);

    // Two-flop synchroniser: LOCK comes from the PLL with no timing relation to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
        end else begin
            lock_meta_reg <= pll_lock;
            lock_s_reg    <= lock_meta_reg;
        end
    end

    // Sequencer: drives PLL reset, the dynamic code buses and the core reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_RST;
            rst_cnt_reg    <= '0;
            timer_reg      <= '0;
            stable_cnt_reg <= '0;
            retry_reg      <= '0;
            pll_reset      <= 1'b1;
            pll_idsel      <= INIT_IDSEL;
            pll_fbdsel     <= INIT_FBDSEL;
            pll_odsel      <= INIT_ODSEL;
            pll_dutyda     <= INIT_DUTYDA;
            cfg_busy       <= 1'b1;
            cfg_done       <= 1'b0;
            cfg_error      <= 1'b0;
            clk_ready      <= 1'b0;
            sys_reset      <= 1'b1;
        end else begin
            cfg_done <= 1'b0;
            case (state_reg)
                ST_RST: begin
                    // Hold RESET for the full count, then release and start the lock timer.
                    if (rst_done) begin
                        state_reg <= ST_WAIT;
                        pll_reset <= 1'b0;
                        timer_reg <= '0;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + 1'b1;
                    end
                end

                ST_WAIT, ST_STABLE: begin
                    if ((state_reg == ST_STABLE) && stable_done) begin
                        // A clean lock wins over a timeout landing on the same edge.
                        state_reg <= ST_READY;
                        clk_ready <= 1'b1;
                        sys_reset <= 1'b0;
                        cfg_busy  <= 1'b0;
                        cfg_done  <= 1'b1;
                        retry_reg <= '0;
                    end else if (timed_out) begin
                        if (retry_left) begin
                            retry_reg   <= retry_reg + 1'b1;
                            state_reg   <= ST_RST;
                            pll_reset   <= 1'b1;
                            rst_cnt_reg <= '0;
                        end else begin
                            state_reg <= ST_ERROR;
                            pll_reset <= 1'b1;
                            cfg_error <= 1'b1;
                            cfg_busy  <= 1'b0;
                        end
                    end else begin
                        // The timer keeps running across lock glitches; only
                        // the stability count restarts.
                        timer_reg <= timer_reg + 1'b1;
                        if (state_reg == ST_WAIT) begin
                            if (lock_s_reg) begin
                                state_reg      <= ST_STABLE;
                                stable_cnt_reg <= '0;
                            end
                        end else if (!lock_s_reg) begin
                            state_reg <= ST_WAIT;
                        end else begin
                            stable_cnt_reg <= stable_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_READY: begin
                    if (cfg_req) begin
                        // New codes go out on the same edge RESET rises.
                        pll_idsel   <= cfg_idsel;
                        pll_fbdsel  <= cfg_fbdsel;
                        pll_odsel   <= cfg_odsel;
                        pll_dutyda  <= cfg_dutyda;
                        pll_reset   <= 1'b1;
                        clk_ready   <= 1'b0;
                        sys_reset   <= 1'b1;
                        cfg_busy    <= 1'b1;
                        retry_reg   <= '0;
                        rst_cnt_reg <= '0;
                        state_reg   <= ST_RST;
                    end else if (!lock_s_reg) begin
                        // Lost lock: fence the core but let the PLL try to
                        // relock on its own before resorting to a reset.
                        clk_ready <= 1'b0;
                        sys_reset <= 1'b1;
                        cfg_busy  <= 1'b1;
                        timer_reg <= '0;
                        state_reg <= ST_WAIT;
                    end
                end

                ST_ERROR: begin
                    // RESET is already high here, so the codes may change now.
                    if (cfg_req) begin
                        pll_idsel   <= cfg_idsel;
                        pll_fbdsel  <= cfg_fbdsel;
                        pll_odsel   <= cfg_odsel;
                        pll_dutyda  <= cfg_dutyda;
                        cfg_error   <= 1'b0;
                        cfg_busy    <= 1'b1;
                        retry_reg   <= '0;
                        rst_cnt_reg <= '0;
                        state_reg   <= ST_RST;
                    end
                end

                default: begin
                    state_reg   <= ST_RST;
                    pll_reset   <= 1'b1;
                    rst_cnt_reg <= '0;
                    cfg_busy    <= 1'b1;
                    cfg_error   <= 1'b0;
                    clk_ready   <= 1'b0;
                    sys_reset   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl
// Randomised bench for pll_reconfig_ctrl. A simple PLL model raises LOCK a
// set number of cycles after RESET falls. Expected timings come from the
// latency rules (reset pulse length, lock-to-ready, loss-to-unready, timeout
// spacing), and expected codes from the last accepted request.
module tb_pll_reconfig_ctrl;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 64;
    localparam int MAX_RETRY    = 2;
    localparam logic [5:0] INIT_IDSEL  = 6'h11;
    localparam logic [5:0] INIT_FBDSEL = 6'h22;
    localparam logic [5:0] INIT_ODSEL  = 6'h2B;
    localparam logic [3:0] INIT_DUTYDA = 4'h8;
    localparam logic [21:0] INIT_CODES = {INIT_IDSEL, INIT_FBDSEL, INIT_ODSEL, INIT_DUTYDA};
    localparam int READY_LAT = LOCK_STABLE + 3;
    localparam int LOSS_LAT  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_req = 1'b0;
    logic [5:0] cfg_idsel = '0;
    logic [5:0] cfg_fbdsel = '0;
    logic [5:0] cfg_odsel = '0;
    logic [3:0] cfg_dutyda = '0;
    logic       cfg_busy, cfg_done, cfg_error, pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [3:0] pll_dutyda;
    logic       pll_lock = 1'b0;
    logic       clk_ready, sys_reset;

    pll_reconfig_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .MAX_RETRY   (MAX_RETRY),
        .INIT_IDSEL  (INIT_IDSEL),
        .INIT_FBDSEL (INIT_FBDSEL),
        .INIT_ODSEL  (INIT_ODSEL),
        .INIT_DUTYDA (INIT_DUTYDA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_req   (cfg_req),
        .cfg_idsel (cfg_idsel),
        .cfg_fbdsel(cfg_fbdsel),
        .cfg_odsel (cfg_odsel),
        .cfg_dutyda(cfg_dutyda),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .pll_reset (pll_reset),
        .pll_idsel (pll_idsel),
        .pll_fbdsel(pll_fbdsel),
        .pll_odsel (pll_odsel),
        .pll_dutyda(pll_dutyda),
        .pll_lock  (pll_lock),
        .clk_ready (clk_ready),
        .sys_reset (sys_reset)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected code bus contents (last accepted request, or INIT after reset).
    logic [21:0] exp_codes = INIT_CODES;

    // PLL model state.
    logic lock_en    = 1'b1;
    logic glitch_now = 1'b0;
    int   lock_delay = 10;
    int   lock_cnt   = 0;
    int   lock_rise_cyc = -1;
    int   lock_fall_cyc = -1;
    int   lock_rises = 0;

    // Event log.
    int   rise_q[$];
    int   fall_q[$];
    int   ready_cyc   = -1;
    int   unready_cyc = -1;
    int   err_cyc     = -1;
    int   done_cnt    = 0;
    logic prev_reset_o = 1'b0;
    logic prev_ready   = 1'b0;
    logic prev_error   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_log();
        rise_q.delete();
        fall_q.delete();
        ready_cyc   = -1;
        unready_cyc = -1;
        err_cyc     = -1;
        done_cnt    = 0;
    endtask

    // Per-cycle observation: event timestamps plus rules that hold every cycle.
    task automatic monitor();
        if (pll_reset && !prev_reset_o) rise_q.push_back(cyc);
        if (!pll_reset && prev_reset_o) fall_q.push_back(cyc);
        if (clk_ready && !prev_ready) ready_cyc = cyc;
        if (!clk_ready && prev_ready) unready_cyc = cyc;
        if (cfg_error && !prev_error) err_cyc = cyc;
        if (cfg_done) done_cnt++;
        check_eq("sys_reset_vs_ready", sys_reset, !clk_ready);
        check_eq("busy_rule", cfg_busy, !clk_ready && !cfg_error);
        check_eq("done_on_ready_entry", cfg_done, clk_ready && !prev_ready);
        check_eq("codes", {pll_idsel, pll_fbdsel, pll_odsel, pll_dutyda}, exp_codes);
        if (cfg_error) check_eq("error_holds_pll_reset", pll_reset, 1'b1);
        prev_reset_o = pll_reset;
        prev_ready   = clk_ready;
        prev_error   = cfg_error;
    endtask

    // PLL: LOCK appears lock_delay cycles after RESET falls, unless disabled.
    task automatic pll_model();
        logic nxt;
        if (pll_reset) begin
            lock_cnt = 0;
            nxt = 1'b0;
        end else begin
            if (lock_cnt < lock_delay) lock_cnt++;
            nxt = lock_en && (lock_cnt >= lock_delay) && !glitch_now;
        end
        if (nxt && !pll_lock) begin
            lock_rise_cyc = cyc;
            lock_rises++;
        end
        if (!nxt && pll_lock) lock_fall_cyc = cyc;
        pll_lock = nxt;
    endtask

    // One clock: observe just after the edge, then drive the next inputs.
    // While the sequencer is busy, stray requests with junk codes are thrown
    // in; they must have no effect.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
        pll_model();
        cfg_req    = cfg_busy && ($urandom_range(0, 7) == 0);
        cfg_idsel  = 6'($urandom);
        cfg_fbdsel = 6'($urandom);
        cfg_odsel  = 6'($urandom);
        cfg_dutyda = 4'($urandom);
    endtask

    // Issue an accepted request (caller ensures READY or ERROR).
    task automatic do_cfg(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o, input logic [3:0] d);
        cfg_idsel  = i;
        cfg_fbdsel = f;
        cfg_odsel  = o;
        cfg_dutyda = d;
        cfg_req    = 1'b1;
        exp_codes  = {i, f, o, d};
        tick();
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!clk_ready && n < budget) begin
            tick();
            n++;
        end
        check_eq("ready_reached", clk_ready, 1'b1);
    endtask

    task automatic wait_lock_rise(input int budget);
        int n0;
        int n;
        n0 = lock_rises;
        n = 0;
        while (lock_rises == n0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("pll_released_before_lock", pll_reset, 1'b0);
    endtask

    // Wait for READY and check lock-to-ready latency and the done pulse.
    task automatic finish_ready(input string tag);
        wait_ready(300);
        check_eq({tag, "_ready_latency"}, ready_cyc - lock_rise_cyc, READY_LAT);
        repeat (3) tick();
        check_eq({tag, "_done_pulses"}, done_cnt, 1);
        check_eq({tag, "_still_ready"}, clk_ready, 1'b1);
    endtask

    task automatic check_first_fall(input string tag, input int base);
        if (fall_q.size() > 0) check_eq(tag, fall_q[0] - base, RST_CYCLES);
        else check_eq({tag, "_missing"}, fall_q.size(), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] ri, rf, ro;
        logic [3:0] rd;
        int rel, req_cyc, lk, off, m, n;

        // Asynchronous reset takes effect without any clock edge.
        #1 reset = 1'b1;
        #1;
        check_eq("rst_pll_reset", pll_reset, 1'b1);
        check_eq("rst_cfg_busy", cfg_busy, 1'b1);
        check_eq("rst_cfg_done", cfg_done, 1'b0);
        check_eq("rst_cfg_error", cfg_error, 1'b0);
        check_eq("rst_clk_ready", clk_ready, 1'b0);
        check_eq("rst_sys_reset", sys_reset, 1'b1);
        check_eq("rst_codes", {pll_idsel, pll_fbdsel, pll_odsel, pll_dutyda}, INIT_CODES);

        // Power-up sequence.
        repeat (3) tick();
        reset = 1'b0;
        rel = cyc;
        clear_log();
        finish_ready("pwrup");
        check_first_fall("pwrup_rst_len", rel);
        check_eq("pwrup_idsel", pll_idsel, INIT_IDSEL);
        $display("powerup: pll_reset fell at %0d, ready at %0d", fall_q.size() > 0 ? fall_q[0] : -1, ready_cyc);

        // Reconfiguration with random codes and PLL lock times.
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                ri = 6'h3C; rf = 6'h35; ro = 6'h38; rd = 4'h8;
                lock_delay = 10;
            end else begin
                ri = 6'($urandom); rf = 6'($urandom); ro = 6'($urandom); rd = 4'($urandom);
                lock_delay = $urandom_range(1, 40);
            end
            clear_log();
            do_cfg(ri, rf, ro, rd);
            req_cyc = cyc;
            check_eq("rcfg_pll_reset", pll_reset, 1'b1);
            check_eq("rcfg_idsel", pll_idsel, ri);
            check_eq("rcfg_busy", cfg_busy, 1'b1);
            check_eq("rcfg_clk_ready", clk_ready, 1'b0);
            finish_ready("rcfg");
            check_first_fall("rcfg_rst_len", req_cyc);
            $display("reconfig %0d: codes %h/%h/%h/%h lock_delay %0d ready at %0d",
                     k, ri, rf, ro, rd, lock_delay, ready_cyc);
        end

        // One-cycle LOCK glitch during the stability window.
        for (int g = 0; g < 4; g++) begin
            lock_delay = 10;
            clear_log();
            do_cfg(6'($urandom), 6'($urandom), 6'($urandom), 4'($urandom));
            wait_lock_rise(100);
            lk  = lock_rise_cyc;
            off = (g == 0) ? 6 : $urandom_range(1, 8);
            while (cyc < lk + off - 1) tick();
            glitch_now = 1'b1;
            tick();
            glitch_now = 1'b0;
            tick();
            finish_ready("glitch");
            check_eq("glitch_no_extra_pulse", rise_q.size(), 1);
            $display("glitch %0d: lock at %0d, dropped at +%0d, ready at %0d", g, lk, off, ready_cyc);
        end

        // Lock loss while READY, then recovery without a PLL reset.
        for (int l = 0; l < 3; l++) begin
            clear_log();
            repeat ($urandom_range(1, 5)) tick();
            lock_en = 1'b0;
            n = 0;
            while (clk_ready && n < 20) begin
                tick();
                n++;
            end
            check_eq("loss_drop", clk_ready, 1'b0);
            check_eq("loss_latency", unready_cyc - lock_fall_cyc, LOSS_LAT);
            check_eq("loss_sys_reset", sys_reset, 1'b1);
            m = $urandom_range(1, 20);
            repeat (m) tick();
            lock_en = 1'b1;
            finish_ready("loss");
            check_eq("loss_no_pll_reset", rise_q.size(), 0);
            $display("lockloss %0d: lost at %0d, ready again at %0d", l, lock_fall_cyc, ready_cyc);
        end

        // Timeout and retry exhaustion.
        lock_en = 1'b0;
        clear_log();
        do_cfg(6'($urandom), 6'($urandom), 6'($urandom), 4'($urandom));
        n = 0;
        while (!cfg_error && n < 600) begin
            tick();
            n++;
        end
        check_eq("to_error", cfg_error, 1'b1);
        check_eq("to_rises", rise_q.size(), MAX_RETRY + 2);
        check_eq("to_falls", fall_q.size(), MAX_RETRY + 1);
        for (int p = 0; p < MAX_RETRY + 1; p++) begin
            if (p < fall_q.size() && p + 1 < rise_q.size()) begin
                check_eq("to_pulse_len", fall_q[p] - rise_q[p], RST_CYCLES);
                check_eq("to_spacing", rise_q[p+1] - fall_q[p], LOCK_TIMEOUT);
            end
        end
        if (rise_q.size() == MAX_RETRY + 2) check_eq("to_error_edge", err_cyc, rise_q[MAX_RETRY+1]);
        repeat (20) tick();
        check_eq("err_pll_reset_stuck", pll_reset, 1'b1);
        check_eq("err_sticky", cfg_error, 1'b1);
        check_eq("err_busy", cfg_busy, 1'b0);
        check_eq("err_no_new_pulse", rise_q.size(), MAX_RETRY + 2);
        $display("timeout: pulses %0d, error at %0d", fall_q.size(), err_cyc);

        lock_en = 1'b1;
        lock_delay = $urandom_range(1, 30);
        clear_log();
        ri = 6'($urandom); rf = 6'($urandom); ro = 6'($urandom); rd = 4'($urandom);
        do_cfg(ri, rf, ro, rd);
        req_cyc = cyc;
        check_eq("err_req_clears", cfg_error, 1'b0);
        check_eq("err_req_pll_reset", pll_reset, 1'b1);
        check_eq("err_req_busy", cfg_busy, 1'b1);
        finish_ready("err_recover");
        check_first_fall("err_recover_rst_len", req_cyc);
        $display("error recovery: codes %h/%h/%h/%h ready at %0d", ri, rf, ro, rd, ready_cyc);

        // Asynchronous reset in the middle of the stability window.
        lock_delay = 10;
        clear_log();
        do_cfg(6'($urandom), 6'($urandom), 6'($urandom), 4'($urandom));
        wait_lock_rise(100);
        lk = lock_rise_cyc;
        while (cyc < lk + 5) tick();
        #3;
        reset = 1'b1;
        exp_codes = INIT_CODES;
        #1;
        check_eq("areset_pll_reset", pll_reset, 1'b1);
        check_eq("areset_sys_reset", sys_reset, 1'b1);
        check_eq("areset_busy", cfg_busy, 1'b1);
        check_eq("areset_codes", {pll_idsel, pll_fbdsel, pll_odsel, pll_dutyda}, INIT_CODES);
        repeat (2) tick();
        reset = 1'b0;
        rel = cyc;
        clear_log();
        finish_ready("areset");
        check_first_fall("areset_rst_len", rel);
        $display("async reset: released at %0d, ready at %0d", rel, ready_cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
Sequencer for the Gowin rPLL in dynamic-select mode. It owns the PLL RESET and the IDSEL/FBDSEL/ODSEL/DUTYDA dynamic buses, and applies a new divider set only while the PLL is held in reset. It waits for a debounced LOCK, retries on lock timeout, and holds the core's system reset until the PLL clock is stable. It runs on the free-running 27 MHz input clock, between the board clock pin, the PLL instance and the core reset tree.

Parameters:
RST_CYCLES, 16, clk cycles pll_reset is held high per (re)start attempt (>=2)
LOCK_TIMEOUT, 65536, clk cycles after pll_reset deassert without reaching READY before a retry
LOCK_STABLE, 1024, consecutive synchronised-lock-high cycles required before READY
MAX_RETRY, 3, retries after the first attempt before entering ERROR
INIT_IDSEL, 6'd0, power-up IDSEL code
INIT_FBDSEL, 6'd0, power-up FBDSEL code
INIT_ODSEL, 6'd0, power-up ODSEL code
INIT_DUTYDA, 4'd8, power-up DUTYDA code

Ports:
clk  in  1  free-running 27 MHz input clock
reset  in  1  asynchronous, active-high
cfg_req  in  1  request to apply cfg_* values; sampled only in READY or ERROR
cfg_idsel  in  6  requested IDSEL code
cfg_fbdsel  in  6  requested FBDSEL code
cfg_odsel  in  6  requested ODSEL code
cfg_dutyda  in  4  requested DUTYDA code
cfg_busy  out  1  sequence in progress (RST/WAIT/STABLE)
cfg_done  out  1  one-cycle pulse on entry to READY
cfg_error  out  1  retries exhausted; sticky until next accepted cfg_req
pll_reset  out  1  to rPLL RESET
pll_idsel  out  6  to rPLL IDSEL
pll_fbdsel  out  6  to rPLL FBDSEL
pll_odsel  out  6  to rPLL ODSEL
pll_dutyda  out  4  to rPLL DUTYDA
pll_lock  in  1  rPLL LOCK; asynchronous to clk
clk_ready  out  1  PLL output clock is valid
sys_reset  out  1  active-high core reset; equals ~clk_ready

Behaviour:
- All outputs are registered. pll_lock passes through a 2-flop synchroniser to lock_s. lock_s drives all decisions.
- Reset values (applied immediately on async reset, no clock edge needed): state=RST, pll_reset=1, pll_* = INIT_*, cfg_busy=1, cfg_done=0, cfg_error=0, clk_ready=0, sys_reset=1, all counters=0, retry=0, synchroniser=0.
- RST: pll_reset=1 for exactly RST_CYCLES cycles. Then pll_reset goes to 0 on the same edge as the move to WAIT. The timeout timer is cleared on that edge.
- WAIT: if lock_s=1, go to STABLE with stable_cnt=0.
- STABLE: if lock_s=0, return to WAIT and keep the timer running. If stable_cnt==LOCK_STABLE-1 and lock_s=1, go to READY, set clk_ready=1, sys_reset=0, cfg_busy=0, pulse cfg_done for one cycle, and clear retry.
- The timeout timer increments every cycle in WAIT and STABLE. When it reaches LOCK_TIMEOUT-1 without entering READY: if retry<MAX_RETRY, increment retry and go to RST; otherwise go to ERROR. Entering READY takes priority over timeout on the same edge.
- READY, when cfg_req=1:
  - latch cfg_* into pll_* on the same edge that pll_reset goes 1;
  - clk_ready=0, sys_reset=1, cfg_busy=1, retry=0;
  - go to RST.
- READY, when lock_s=0 and cfg_req=0: clk_ready=0, sys_reset=1, cfg_busy=1, timer cleared, go to WAIT. No PLL reset is issued.
- READY with simultaneous cfg_req and lock loss: cfg_req wins.
- ERROR: pll_reset=1, cfg_error=1, cfg_busy=0, sys_reset=1. On cfg_req, latch cfg_*, clear cfg_error and retry, and go to RST.
- cfg_req in RST/WAIT/STABLE is ignored; requesters must check cfg_busy first.
- pll_* codes change only on an edge where pll_reset becomes or remains 1.
- Latency:
  - lock_s rises 2 edges after pll_lock.
  - clk_ready rises LOCK_STABLE+3 edges after pll_lock rises, given an uninterrupted lock in WAIT.
  - Lock loss in READY drops clk_ready 3 edges after pll_lock falls.
- Counters are sized with $clog2 of their limit and never wrap: they saturate, or are cleared on state entry.

Test Plan:
Settings for all scenarios: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, MAX_RETRY=2.
- Power-up: release reset; the PLL model raises pll_lock 10 cycles after pll_reset falls -> pll_reset high exactly 4 cycles, pll_idsel=INIT_IDSEL, clk_ready/sys_reset flip 11 edges after pll_lock rises, cfg_done high exactly 1 cycle.
- Reconfig: in READY, pulse cfg_req with idsel=6'h3C, fbdsel=6'h35, odsel=6'h38, dutyda=4'h8 -> on the next edge pll_reset=1, pll_idsel=6'h3C (same edge), cfg_busy=1, clk_ready=0; after relock, READY again with cfg_done pulse.
- Lock glitch: drop pll_lock for 1 cycle when stable_cnt=5 -> return to WAIT, no pll_reset pulse, clk_ready delayed until 8 consecutive lock_s-high cycles.
- Timeout/retry: pll_lock held 0 -> exactly 3 pll_reset pulses of 4 cycles, spaced 64 cycles after each deassert, then cfg_error=1 and pll_reset stuck 1; cfg_req then clears cfg_error and starts a new pulse.
- Lock loss in READY: pll_lock falls -> clk_ready=0 and sys_reset=1 3 edges later, pll_reset stays 0; pll_lock returns -> READY after 11 edges.
- Async reset mid-STABLE: assert reset between clock edges -> pll_reset=1, sys_reset=1, pll_*=INIT_* immediately; the full sequence restarts after release.
